jtframe_inputs_multi: RTL and testbench

Parametrised player-input conditioner between the board joystick/keyboard merge and the game core, generalising the fixed two-player joystick/coin/start path to N players and M buttons. Synchronises and debounces every raw input, shapes coins into frame-timed pulses, applies per-button autofire, and owns the pause toggle. All game-facing outputs are registered and emitted in the polarity the game core expects.

---
 rtl/jtframe_inputs_multi.sv | 241 ++++++++++++++++++++++++
 tb/tb_jtframe_inputs_multi.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_inputs_multi.sv
// jtframe_inputs_multi
// Player-input conditioner for PLAYERS x BUTTONS: synchronises and debounces
// every raw key, turns coins into frame-timed pulses, applies per-button
// autofire and owns the pause toggle. Game-facing outputs are registered.
module jtframe_inputs_multi #(
    parameter int PLAYERS         = 2,
    parameter int BUTTONS         = 6,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEB_CYCLES      = 4,
    parameter int COIN_FRAMES     = 4,
    parameter int AUTOFIRE_FRAMES = 3
) (
    input  logic                            clk_sys,
    input  logic                            rst_n,
    input  logic [PLAYERS*(4+BUTTONS)-1:0]  raw_joy,
    input  logic [PLAYERS-1:0]              raw_coin,
    input  logic [PLAYERS-1:0]              raw_start,
    input  logic                            raw_pause,
    input  logic                            raw_service,
    input  logic [BUTTONS-1:0]              autofire_en,
    input  logic                            vs,
    input  logic                            downloading,
    output logic [PLAYERS*(4+BUTTONS)-1:0]  game_joy,
    output logic [PLAYERS-1:0]              game_coin,
    output logic [PLAYERS-1:0]              game_start,
    output logic                            game_service,
    output logic                            game_pause
);

    localparam int JW     = 4 + BUTTONS;
    localparam int JWT    = PLAYERS * JW;
    localparam int NB     = JWT + 2*PLAYERS + 2;
    localparam int DCW    = $clog2(DEB_CYCLES + 1);
    localparam int CFW    = $clog2(COIN_FRAMES + 1);
    localparam int AFW    = $clog2(AUTOFIRE_FRAMES + 1);
    // A coin held through reset would look like a fresh rising edge once the
    // debouncer catches up; coin edges are ignored until that has happened.
    localparam int SETTLE = DEB_CYCLES + 3;
    localparam int STW    = $clog2(SETTLE + 1);

    localparam logic [1:0] COIN_IDLE   = 2'd0;
    localparam logic [1:0] COIN_ACTIVE = 2'd1;
    localparam logic [1:0] COIN_HOLD   = 2'd2;

    logic [NB-1:0]      w_raw;
    logic [NB-1:0]      r_sync1;
    logic [NB-1:0]      r_sync2;
    logic [NB-1:0]      r_deb;
    logic [DCW-1:0]     r_deb_cnt [NB];
    logic               r_vs1;
    logic               r_vs2;
    logic               r_vs3;
    logic               w_frame_tick;
    logic [JWT-1:0]     w_deb_joy;
    logic [PLAYERS-1:0] w_deb_coin;
    logic [PLAYERS-1:0] w_deb_start;
    logic               w_deb_pause;
    logic               w_deb_service;
    logic [PLAYERS-1:0] r_coin_prev;
    logic               r_pause_prev;
    logic [STW-1:0]     r_settle;
    logic               w_settled;
    logic [PLAYERS-1:0] w_coin_rise;
    logic [1:0]         r_coin_st  [PLAYERS];
    logic [CFW-1:0]     r_coin_frm [PLAYERS];
    logic [PLAYERS-1:0] w_coin_act;
    logic [AFW-1:0]     r_af_cnt;
    logic               r_af_phase;
    logic               r_pause;
    logic [JWT-1:0]     w_joy_cond;

    assign w_raw = {raw_service, raw_pause, raw_start, raw_coin, raw_joy};

    // two-flop synchroniser on every raw key
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // vs synchroniser plus edge register for the frame tick
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_vs1 <= 1'b0;
            r_vs2 <= 1'b0;
            r_vs3 <= 1'b0;
        end else begin
            r_vs1 <= vs;
            r_vs2 <= r_vs1;
            r_vs3 <= r_vs2;
        end
    end

    assign w_frame_tick = r_vs2 & ~r_vs3;

    // per-bit debounce: a change must persist DEB_CYCLES consecutive cycles
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_deb <= '0;
            for (int unsigned i = 0; i < NB; i++) r_deb_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DCW'(DEB_CYCLES - 1)) begin
                    r_deb[i]     <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + DCW'(1);
                end
            end
        end
    end

    assign w_deb_joy     = r_deb[JWT-1:0];
    assign w_deb_coin    = r_deb[JWT +: PLAYERS];
    assign w_deb_start   = r_deb[JWT+PLAYERS +: PLAYERS];
    assign w_deb_pause   = r_deb[NB-2];
    assign w_deb_service = r_deb[NB-1];

    // previous debounced coin/pause for rising-edge detection, plus settle timer
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_coin_prev  <= '0;
            r_pause_prev <= 1'b0;
            r_settle     <= '0;
        end else begin
            r_coin_prev  <= w_deb_coin;
            r_pause_prev <= w_deb_pause;
            if (!w_settled) r_settle <= r_settle + STW'(1);
        end
    end

    assign w_settled   = (r_settle == STW'(SETTLE));
    assign w_coin_rise = w_deb_coin & ~r_coin_prev & {PLAYERS{w_settled}};

    // per-player coin FSM: one COIN_FRAMES-long pulse per coin insertion
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned p = 0; p < PLAYERS; p++) begin
                r_coin_st[p]  <= COIN_IDLE;
                r_coin_frm[p] <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < PLAYERS; p++) begin
                if (downloading) begin
                    r_coin_st[p]  <= COIN_IDLE;
                    r_coin_frm[p] <= '0;
                end else begin
                    case (r_coin_st[p])
                        COIN_IDLE: begin
                            if (w_coin_rise[p]) begin
                                r_coin_st[p]  <= COIN_ACTIVE;
                                r_coin_frm[p] <= '0;
                            end
                        end
                        COIN_ACTIVE: begin
                            if (w_frame_tick) begin
                                if (r_coin_frm[p] == CFW'(COIN_FRAMES - 1)) begin
                                    r_coin_st[p]  <= COIN_HOLD;
                                    r_coin_frm[p] <= '0;
                                end else begin
                                    r_coin_frm[p] <= r_coin_frm[p] + CFW'(1);
                                end
                            end
                        end
                        COIN_HOLD: begin
                            if (!w_deb_coin[p]) r_coin_st[p] <= COIN_IDLE;
                        end
                        default: r_coin_st[p] <= COIN_IDLE;
                    endcase
                end
            end
        end
    end

    // decode which players currently assert a coin pulse
    always_comb begin
        w_coin_act = '0;
        for (int unsigned p = 0; p < PLAYERS; p++)
            w_coin_act[p] = (r_coin_st[p] == COIN_ACTIVE);
    end

    // global autofire phase, toggles every AUTOFIRE_FRAMES frames
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_af_cnt   <= '0;
            r_af_phase <= 1'b1;
        end else if (w_frame_tick) begin
            if (r_af_cnt == AFW'(AUTOFIRE_FRAMES - 1)) begin
                r_af_cnt   <= '0;
                r_af_phase <= ~r_af_phase;
            end else begin
                r_af_cnt <= r_af_cnt + AFW'(1);
            end
        end
    end

    // pause toggles once per debounced key press, cleared during download
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n)                            r_pause <= 1'b0;
        else if (downloading)                  r_pause <= 1'b0;
        else if (w_deb_pause && !r_pause_prev) r_pause <= ~r_pause;
    end

    assign game_pause = r_pause;

    // gate autofire-enabled buttons with the autofire phase
    always_comb begin
        w_joy_cond = w_deb_joy;
        for (int unsigned p = 0; p < PLAYERS; p++)
            for (int unsigned b = 0; b < BUTTONS; b++)
                if (autofire_en[b])
                    w_joy_cond[p*JW + 4 + b] = w_deb_joy[p*JW + 4 + b] & r_af_phase;
    end

    // output register: game polarity applied here only, idle while downloading
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            game_joy     <= {JWT{ACTIVE_LOW}};
            game_coin    <= {PLAYERS{ACTIVE_LOW}};
            game_start   <= {PLAYERS{ACTIVE_LOW}};
            game_service <= ACTIVE_LOW;
        end else if (downloading) begin
            game_joy     <= {JWT{ACTIVE_LOW}};
            game_coin    <= {PLAYERS{ACTIVE_LOW}};
            game_start   <= {PLAYERS{ACTIVE_LOW}};
            game_service <= ACTIVE_LOW;
        end else begin
            game_joy     <= w_joy_cond  ^ {JWT{ACTIVE_LOW}};
            game_coin    <= w_coin_act  ^ {PLAYERS{ACTIVE_LOW}};
            game_start   <= w_deb_start ^ {PLAYERS{ACTIVE_LOW}};
            game_service <= w_deb_service ^ ACTIVE_LOW;
        end
    end

endmodule

// File: tb/tb_jtframe_inputs_multi.sv
// Scoreboard bench for jtframe_inputs_multi: a reference model derives the
// expected outputs from the raw input history each clock, a monitor compares.
module tb_jtframe_inputs_multi;

    localparam int PLAYERS = 2;
    localparam int BUTTONS = 6;
    localparam bit ACTIVE_LOW = 1'b1;
    localparam int DEB   = 4;
    localparam int COINF = 4;
    localparam int AFF   = 3;
    localparam int JW    = 4 + BUTTONS;
    localparam int JWT   = PLAYERS * JW;
    localparam int NB    = JWT + 2*PLAYERS + 2;
    localparam int HMAX  = 4096;

    logic               clk_sys = 1'b0;
    logic               rst_n = 1'b0;
    logic [JWT-1:0]     raw_joy = '0;
    logic [PLAYERS-1:0] raw_coin = '0;
    logic [PLAYERS-1:0] raw_start = '0;
    logic               raw_pause = 1'b0;
    logic               raw_service = 1'b0;
    logic [BUTTONS-1:0] autofire_en = '0;
    logic               vs = 1'b0;
    logic               downloading = 1'b0;
    logic [JWT-1:0]     game_joy;
    logic [PLAYERS-1:0] game_coin;
    logic [PLAYERS-1:0] game_start;
    logic               game_service;
    logic               game_pause;

    jtframe_inputs_multi #(
        .PLAYERS(PLAYERS), .BUTTONS(BUTTONS), .ACTIVE_LOW(ACTIVE_LOW),
        .DEB_CYCLES(DEB), .COIN_FRAMES(COINF), .AUTOFIRE_FRAMES(AFF)
    ) dut (
        .clk_sys(clk_sys), .rst_n(rst_n),
        .raw_joy(raw_joy), .raw_coin(raw_coin), .raw_start(raw_start),
        .raw_pause(raw_pause), .raw_service(raw_service),
        .autofire_en(autofire_en), .vs(vs), .downloading(downloading),
        .game_joy(game_joy), .game_coin(game_coin), .game_start(game_start),
        .game_service(game_service), .game_pause(game_pause)
    );

    always #5 clk_sys = ~clk_sys;

    int unsigned errors = 0;
    int unsigned checks = 0;

    typedef struct {
        logic [JWT-1:0]     joy;
        logic [PLAYERS-1:0] coin;
        logic [PLAYERS-1:0] start;
        logic               service;
        logic               pause;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t idle_exp();
        exp_t e;
        e.joy     = {JWT{ACTIVE_LOW}};
        e.coin    = {PLAYERS{ACTIVE_LOW}};
        e.start   = {PLAYERS{ACTIVE_LOW}};
        e.service = ACTIVE_LOW;
        e.pause   = 1'b0;
        return e;
    endfunction

    // ---------------- reference model ----------------
    // Debounced value follows the raw key once the key has held a value for
    // DEB consecutive synchronised samples; synchroniser = 2-sample delay.
    logic [NB-1:0] m_hist [HMAX];
    logic          m_vs_hist [HMAX];
    logic [NB-1:0] m_deb, m_deb_prev;
    int            m_k, m_ticks;
    int            m_left [PLAYERS];
    bit            m_latched [PLAYERS];
    bit            m_pause;

    function automatic logic [NB-1:0] hist_at(input int j);
        if (j < 1) return '0;
        return m_hist[j % HMAX];
    endfunction

    function automatic logic vs_at(input int j);
        if (j < 1) return 1'b0;
        return m_vs_hist[j % HMAX];
    endfunction

    task automatic model_reset();
        m_k = 0; m_ticks = 0; m_deb = '0; m_deb_prev = '0; m_pause = 0;
        for (int p = 0; p < PLAYERS; p++) begin m_left[p] = 0; m_latched[p] = 0; end
    endtask

    initial begin : model
        exp_t          e;
        logic [JWT-1:0] joy;
        logic [PLAYERS-1:0] cv;
        logic [NB-1:0] hv;
        bit ph, tick, dc, rise, all1, all0;
        model_reset();
        forever begin
            @(posedge clk_sys);
            if (!rst_n) begin
                model_reset();
                exp_q.push_back(idle_exp());
            end else begin
                m_k++;
                ph = ((m_ticks / AFF) % 2) == 0;
                joy = m_deb[JWT-1:0];
                for (int p = 0; p < PLAYERS; p++)
                    for (int b = 0; b < BUTTONS; b++)
                        if (autofire_en[b] && !ph) joy[p*JW + 4 + b] = 1'b0;
                for (int p = 0; p < PLAYERS; p++) cv[p] = (m_left[p] > 0);
                if (downloading) e = idle_exp();
                else begin
                    e.joy     = joy ^ {JWT{ACTIVE_LOW}};
                    e.coin    = cv ^ {PLAYERS{ACTIVE_LOW}};
                    e.start   = m_deb[JWT+PLAYERS +: PLAYERS] ^ {PLAYERS{ACTIVE_LOW}};
                    e.service = m_deb[NB-1] ^ ACTIVE_LOW;
                end
                tick = vs_at(m_k - 2) && !vs_at(m_k - 3);
                for (int p = 0; p < PLAYERS; p++) begin
                    dc   = m_deb[JWT+p];
                    rise = dc && !m_deb_prev[JWT+p] && (m_k >= DEB + 4);
                    if (downloading) begin m_left[p] = 0; m_latched[p] = 0; end
                    else if (m_left[p] > 0) begin if (tick) m_left[p]--; end
                    else if (m_latched[p]) begin if (!dc) m_latched[p] = 0; end
                    else if (rise) begin m_left[p] = COINF; m_latched[p] = 1; end
                end
                if (downloading) m_pause = 0;
                else if (m_deb[NB-2] && !m_deb_prev[NB-2]) m_pause = !m_pause;
                e.pause = m_pause;
                if (tick) m_ticks++;
                m_hist[m_k % HMAX]    = {raw_service, raw_pause, raw_start, raw_coin, raw_joy};
                m_vs_hist[m_k % HMAX] = vs;
                m_deb_prev = m_deb;
                for (int i = 0; i < NB; i++) begin
                    all1 = 1; all0 = 1;
                    for (int j = m_k - 1 - DEB; j <= m_k - 2; j++) begin
                        hv = hist_at(j);
                        if (hv[i]) all0 = 0; else all1 = 0;
                    end
                    if (all1) m_deb[i] = 1'b1;
                    if (all0) m_deb[i] = 1'b0;
                end
                exp_q.push_back(e);
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_sys);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (!rst_n) e = idle_exp();
                check("joy",     game_joy,     e.joy);
                check("coin",    game_coin,    e.coin);
                check("start",   game_start,   e.start);
                check("service", game_service, e.service);
                check("pause",   game_pause,   e.pause);
            end
        end
    end

    // frame sync: 20-cycle frames
    initial begin : vs_gen
        forever begin
            repeat (14) @(posedge clk_sys);
            #1 vs = 1'b1;
            repeat (6) @(posedge clk_sys);
            #1 vs = 1'b0;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        exp_t idl;
        int   pulses, lows, toggles;
        logic prev;
        bit   seen;
        logic [NB-1:0] v;
        idl = idle_exp();

        repeat (3) @(posedge clk_sys);
        #2;
        check("rst_joy",   game_joy,   idl.joy);
        check("rst_coin",  game_coin,  2'b11);
        check("rst_pause", game_pause, 1'b0);
        @(posedge clk_sys); #1 rst_n = 1'b1;
        repeat (12) @(posedge clk_sys);

        // P1 up: exact latency of DEB+3 clocks
        @(posedge clk_sys); #1 raw_joy[3] = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk_sys); #2;
            check("up_latency", game_joy[3], (n >= 7) ? 1'b0 : 1'b1);
        end
        // 3-cycle glitch on P1 right must not propagate
        @(posedge clk_sys); #1 raw_joy[0] = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1 raw_joy[0] = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk_sys); #2;
            check("glitch", game_joy[0], 1'b1);
        end
        #1 raw_joy[3] = 1'b0;
        repeat (10) @(posedge clk_sys);

        // P2 coin held 20 frames: one pulse of 4 frames
        for (int r = 0; r < 2; r++) begin
            @(posedge clk_sys); #1 raw_coin[1] = 1'b1;
            pulses = 0; lows = 0; prev = 1'b1;
            for (int n = 0; n < 400; n++) begin
                @(posedge clk_sys); #2;
                if (!game_coin[1]) lows++;
                if (prev && !game_coin[1]) pulses++;
                prev = game_coin[1];
            end
            check("coin_pulses", pulses, 1);
            check("coin_len", (lows >= 61 && lows <= 80), 1);
            #1 raw_coin[1] = 1'b0;
            repeat (40) @(posedge clk_sys);
        end

        // autofire on button0, P2
        @(posedge clk_sys); #1 autofire_en[0] = 1'b1; raw_joy[JW+4] = 1'b1;
        repeat (10) @(posedge clk_sys);
        #2 prev = game_joy[JW+4]; toggles = 0;
        for (int n = 0; n < 280; n++) begin
            @(posedge clk_sys); #2;
            if (game_joy[JW+4] !== prev) toggles++;
            prev = game_joy[JW+4];
        end
        check("af_toggles", (toggles >= 4 && toggles <= 5), 1);
        #1 autofire_en[0] = 1'b0;
        repeat (2) @(posedge clk_sys);
        lows = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk_sys); #2;
            if (!game_joy[JW+4]) lows++;
        end
        check("af_off_steady", lows, 100);
        #1 raw_joy[JW+4] = 1'b0;
        repeat (10) @(posedge clk_sys);

        // pause toggling
        for (int r = 0; r < 3; r++) begin
            #1 raw_pause = 1'b1;
            repeat (10) @(posedge clk_sys);
            #1 raw_pause = 1'b0;
            repeat (20) @(posedge clk_sys);
            #2 check("pause_toggle", game_pause, (r % 2 == 0) ? 1'b1 : 1'b0);
            @(posedge clk_sys);
        end
        // download while paused with P1 left held
        #1 raw_joy[1] = 1'b1;
        repeat (10) @(posedge clk_sys);
        #1 downloading = 1'b1;
        repeat (2) @(posedge clk_sys);
        #2 check("dl_pause", game_pause, 1'b0);
        check("dl_joy_idle", game_joy, idl.joy);
        repeat (12) @(posedge clk_sys);
        #1 downloading = 1'b0;
        repeat (2) @(posedge clk_sys);
        #2 check("dl_release_joy", game_joy[1], 1'b0);
        check("dl_release_pause", game_pause, 1'b0);
        #1 raw_joy[1] = 1'b0;
        repeat (10) @(posedge clk_sys);

        // async reset in the middle of a P1 coin pulse
        #1 raw_coin[0] = 1'b1;
        seen = 0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(posedge clk_sys); #2;
            if (!game_coin[0]) seen = 1;
        end
        check("coin0_active", seen, 1);
        repeat (5) @(posedge clk_sys);
        #3 rst_n = 1'b0;
        #1 check("async_rst_coin", game_coin, 2'b11);
        check("async_rst_joy", game_joy, idl.joy);
        check("async_rst_pause", game_pause, 1'b0);
        repeat (3) @(posedge clk_sys);
        #1 rst_n = 1'b1;
        lows = 0;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk_sys); #2;
            if (!game_coin[0]) lows++;
        end
        check("no_pulse_after_rst", lows, 0);
        #1 raw_coin[0] = 1'b0;
        repeat (10) @(posedge clk_sys);

        // randomized traffic
        for (int n = 0; n < 1200; n++) begin
            @(posedge clk_sys); #1;
            if ($urandom_range(2) == 0) begin
                v = {raw_service, raw_pause, raw_start, raw_coin, raw_joy};
                v[$urandom_range(NB-1)] ^= 1'b1;
                {raw_service, raw_pause, raw_start, raw_coin, raw_joy} = v;
            end
            if ($urandom_range(49) == 0) autofire_en = BUTTONS'($urandom);
            if ($urandom_range(149) == 0) downloading = ~downloading;
        end
        @(posedge clk_sys); #1 downloading = 1'b0;
        repeat (20) @(posedge clk_sys);
        @(negedge clk_sys); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
